// File: rtl/obj_row_gen.sv
// Sprite row/column address generator: Y-hit test, per-line sprite limit, valid/ready fetch stream.
// Optional OBJ_STATS_EN adds a per-line hit counter and a sprite-disable attribute bit.
module obj_row_gen #(
  parameter int YW        = 8,
  parameter int OBJ_H     = 16,
  parameter int COL_STEPS = 4,
  parameter int MAX_SPR   = 8,
  localparam int ROW_BITS = $clog2(OBJ_H),
  localparam int COL_BITS = $clog2(COL_STEPS),
  localparam int AW       = COL_BITS + ROW_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cen,
  input  logic                line_start,
  input  logic [YW-1:0]       vcnt,
  input  logic                y_stb,
  input  logic [YW-1:0]       obj_y,
  input  logic                attr_stb,
  input  logic [7:0]          obj_attr,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [AW-1:0]       r_addr,
  output logic                r_last,
  output logic                busy,
  output logic                ovf
`ifdef OBJ_STATS_EN
  , output logic [7:0]        hit_cnt
`endif
);

  // state     | meaning
  // IDLE      | waiting for an object Y byte
  // WAIT_ATTR | hit/row captured, waiting for the attribute byte
  // EMIT      | streaming COL_STEPS fetch addresses for the accepted sprite
  typedef enum logic [1:0] {IDLE, WAIT_ATTR, EMIT} state_t;

  state_t              state_q, state_d;
  logic                hit_q, hit_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                flipx_q, flipx_d;
  logic                flipy_q, flipy_d;
  logic [7:0]          count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          hcnt_q, hcnt_d;

  logic [YW-1:0]       sum;
  logic                sum_hit;
  logic                hit_eff;
  logic                emit;
  logic                last_col;

  assign sum     = obj_y + vcnt;
  assign sum_hit = &sum[YW-1:ROW_BITS];

`ifdef OBJ_STATS_EN
  assign hit_eff = hit_q & ~obj_attr[2];
  assign hit_cnt = hcnt_q;
  logic unused_attr;
  assign unused_attr = ^obj_attr[7:3];
`else
  assign hit_eff = hit_q;
  logic unused_attr;
  assign unused_attr = ^{obj_attr[7:2], hcnt_q};
`endif

  assign emit     = (state_q == EMIT);
  assign last_col = (col_q == COL_BITS'(COL_STEPS - 1));
  assign r_valid  = emit;
  assign r_last   = emit & last_col;
  assign r_addr   = emit ? {col_q ^ {COL_BITS{flipx_q}}, row_q ^ {ROW_BITS{flipy_q}}} : '0;
  assign busy     = (state_q != IDLE);
  assign ovf      = ovf_q;

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    row_d   = row_q;
    col_d   = col_q;
    flipx_d = flipx_q;
    flipy_d = flipy_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    hcnt_d  = hcnt_q;
    if (line_start) begin
      state_d = IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (y_stb) begin
            hit_d   = sum_hit;
            row_d   = sum[ROW_BITS-1:0];
            state_d = WAIT_ATTR;
          end
        end
        WAIT_ATTR: begin
          if (attr_stb) begin
            state_d = IDLE;
            if (hit_eff) begin
              // overflowed hits still count toward the statistics
              if (hcnt_q != 8'hFF) hcnt_d = hcnt_q + 8'd1;
              if (count_q < 8'(MAX_SPR)) begin
                flipx_d = obj_attr[0];
                flipy_d = obj_attr[1];
                count_d = count_q + 8'd1;
                col_d   = '0;
                state_d = EMIT;
              end else begin
                ovf_d = 1'b1;
              end
            end
          end
        end
        EMIT: begin
          if (r_ready) begin
            if (last_col) state_d = IDLE;
            else          col_d   = col_q + COL_BITS'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      flipx_q <= 1'b0;
      flipy_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      hcnt_q  <= '0;
    end else if (cen) begin
      state_q <= state_d;
      hit_q   <= hit_d;
      row_q   <= row_d;
      col_q   <= col_d;
      flipx_q <= flipx_d;
      flipy_q <= flipy_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      hcnt_q  <= hcnt_d;
    end
  end

endmodule

// File: tb/tb_obj_row_gen.sv
// Scoreboard bench for obj_row_gen (MAX_SPR=2 so the per-line limit is reachable).
module tb_obj_row_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cen = 1'b1;
  logic       line_start = 1'b0;
  logic [7:0] vcnt = '0;
  logic       y_stb = 1'b0;
  logic [7:0] obj_y = '0;
  logic       attr_stb = 1'b0;
  logic [7:0] obj_attr = '0;
  logic       r_valid;
  logic       r_ready = 1'b1;
  logic [5:0] r_addr;
  logic       r_last;
  logic       busy;
  logic       ovf;
`ifdef OBJ_STATS_EN
  logic [7:0] hit_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] sb[$];
  logic cen_tog = 1'b0;

  obj_row_gen #(.YW(8), .OBJ_H(16), .COL_STEPS(4), .MAX_SPR(2)) dut (
    .clk(clk), .reset(reset), .cen(cen), .line_start(line_start), .vcnt(vcnt),
    .y_stb(y_stb), .obj_y(obj_y), .attr_stb(attr_stb), .obj_attr(obj_attr),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr), .r_last(r_last),
    .busy(busy), .ovf(ovf)
`ifdef OBJ_STATS_EN
    , .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cen_tog) begin #1; cen = ~cen; end

  // monitor: every handshake that will be taken at the next edge must match the queue head
  always @(negedge clk) begin
    if (!reset && r_valid && r_ready && cen) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got addr=%02h last=%0d, required no output", r_addr, r_last);
      end else begin
        logic [6:0] e;
        e = sb.pop_front();
        if ({r_last, r_addr} !== e) begin
          miscompares++;
          $display("FAIL stream_word: got addr=%02h last=%0d, required addr=%02h last=%0d",
                   r_addr, r_last, e[5:0], e[6]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cen_edge();
    logic c;
    do begin
      @(posedge clk); c = cen; #1;
    end while (!c);
  endtask

  task automatic new_line();
    line_start = 1'b1; cen_edge(); line_start = 1'b0;
  endtask

  task automatic send_sprite(input logic [7:0] y, input logic [7:0] attr);
    obj_y = y; y_stb = 1'b1; cen_edge(); y_stb = 1'b0;
    obj_attr = attr; attr_stb = 1'b1; cen_edge(); attr_stb = 1'b0;
  endtask

  task automatic push4(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2, input logic [5:0] a3);
    sb.push_back({1'b0, a0}); sb.push_back({1'b0, a1});
    sb.push_back({1'b0, a2}); sb.push_back({1'b1, a3});
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 60; n++) begin
      tick();
      if (sb.size() == 0 && !busy) break;
    end
    vectors++;
    if (n == 60) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d words outstanding, busy=%0d, required 0 and idle", name, sb.size(), busy);
    end
  endtask

  initial begin
    #12;
    check("reset_r_valid", r_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);
    check("reset_r_addr", r_addr, 0);
    @(posedge clk); #1; reset = 1'b0;
    tick();

    // basic hit: sum 0xF5
    new_line(); vcnt = 8'h20;
    push4(6'h05, 6'h15, 6'h25, 6'h35);
    send_sprite(8'hD5, 8'h00);
    check("basic_first_valid", r_valid, 1);
    repeat (4) tick();
    check("basic_busy_drop", busy, 0);
    check("basic_drained", sb.size(), 0);

    // flips
    new_line();
    push4(6'h3A, 6'h2A, 6'h1A, 6'h0A);
    send_sprite(8'hD5, 8'h03);
    wait_idle("flips");

    // miss
    new_line();
    send_sprite(8'h10, 8'h00);
    check("miss_busy", busy, 0);
    check("miss_valid", r_valid, 0);

    // wrap: 0x7F + 0x80 = 0xFF
    vcnt = 8'h80;
    push4(6'h0F, 6'h1F, 6'h2F, 6'h3F);
    send_sprite(8'h7F, 8'h00);
    wait_idle("wrap");

    // back-pressure
    new_line(); vcnt = 8'h20; r_ready = 1'b0;
    push4(6'h05, 6'h15, 6'h25, 6'h35);
    send_sprite(8'hD5, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid_hold", r_valid, 1);
      check("bp_addr_hold", r_addr, 6'h05);
      tick();
    end
    r_ready = 1'b1;
    wait_idle("bp");

    // back-pressure with cen toggling
    new_line(); r_ready = 1'b0; cen_tog = 1'b1;
    push4(6'h05, 6'h15, 6'h25, 6'h35);
    send_sprite(8'hD5, 8'h00);
    for (int i = 0; i < 6; i++) begin
      check("bpcen_valid_hold", r_valid, 1);
      check("bpcen_addr_hold", r_addr, 6'h05);
      tick();
    end
    r_ready = 1'b1;
    wait_idle("bpcen");
    cen_tog = 1'b0; tick(); cen = 1'b1; tick();

    // sprite limit (MAX_SPR=2)
    new_line();
    push4(6'h05, 6'h15, 6'h25, 6'h35);
    send_sprite(8'hD5, 8'h00); wait_idle("lim1");
    push4(6'h3A, 6'h2A, 6'h1A, 6'h0A);
    send_sprite(8'hD5, 8'h03); wait_idle("lim2");
    check("lim_ovf_before", ovf, 0);
    send_sprite(8'hD5, 8'h00);
    check("lim_third_dropped", r_valid, 0);
    check("lim_ovf_set", ovf, 1);
    tick();
    check("lim_ovf_sticky", ovf, 1);
    new_line();
    check("lim_ovf_cleared", ovf, 0);
    push4(6'h0F, 6'h1F, 6'h2F, 6'h3F);
    vcnt = 8'h80;
    send_sprite(8'h7F, 8'h00); wait_idle("lim_after");

    // abort during second word
    new_line(); vcnt = 8'h20;
    sb.push_back({1'b0, 6'h05});
    send_sprite(8'hD5, 8'h00);
    tick();
    check("abort_second_word", r_addr, 6'h15);
    r_ready = 1'b0; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check("abort_valid", r_valid, 0);
    check("abort_busy", busy, 0);
    r_ready = 1'b1;

    // line_start coincident with y_stb
    obj_y = 8'hD5; y_stb = 1'b1; line_start = 1'b1;
    tick();
    y_stb = 1'b0; line_start = 1'b0;
    check("ls_y_dropped_busy", busy, 0);
    obj_attr = 8'h00; attr_stb = 1'b1;
    tick();
    attr_stb = 1'b0;
    check("ls_attr_ignored", r_valid, 0);

    // async reset mid-EMIT
    new_line(); r_ready = 1'b0;
    send_sprite(8'hD5, 8'h00);
    check("pre_reset_valid", r_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("areset_valid", r_valid, 0);
    check("areset_busy", busy, 0);
    check("areset_addr", r_addr, 0);
    check("areset_last", r_last, 0);
    check("areset_ovf", ovf, 0);
    @(posedge clk); #1; reset = 1'b0; r_ready = 1'b1;
    tick();

    check("final_queue_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/obj_row_gen.md
Name: obj_row_gen

Overview:
- Clocked, parametrised successor to the combinational sprite-row logic used by the object pipeline.
- Per sprite, it takes the Y byte and then the attribute byte from sprite RAM and adds Y to the vertical counter to test whether the sprite is on the line.
- For a hit, it emits one line-ROM row/column address per fetch step over a valid/ready stream.
- It enforces a per-line sprite limit and flags overflow; it sits between the sprite RAM scanner and the sprite ROM address mux.

Parameters:
- YW, 8, width of vertical counter and object Y.
- OBJ_H, 16, sprite height in lines; power of two, 2..2^(YW-1); ROW_BITS = clog2(OBJ_H).
- COL_STEPS, 4, fetch words per sprite line; power of two ≥2; COL_BITS = clog2(COL_STEPS).
- MAX_SPR, 8, maximum sprites accepted per line, 1..255.

Ports:
- clk  in  1  master clock.
- reset  in  1  asynchronous, active-high reset.
- cen  in  1  clock enable; state advances only on clk edges with cen=1.
- line_start  in  1  start of a new scanline; clears the per-line counter and aborts any sprite.
- vcnt  in  YW  vertical counter for the line being built.
- y_stb  in  1  obj_y is valid.
- obj_y  in  YW  object Y byte.
- attr_stb  in  1  obj_attr is valid.
- obj_attr  in  8  [0]=flipx, [1]=flipy; other bits ignored unless OBJ_STATS_EN.
- r_valid  out  1  r_addr is valid.
- r_ready  in  1  downstream accepts.
- r_addr  out  COL_BITS+ROW_BITS  {col, row}.
- r_last  out  1  last fetch word of the sprite.
- busy  out  1  FSM is not IDLE.
- ovf  out  1  sprite limit exceeded on this line.

Behaviour:
- Reset (async): state=IDLE; r_valid=0, r_addr=0, r_last=0, busy=0, ovf=0; count=0, col=0, row=0, flips=0.
- All sequential actions below require cen=1; when cen=0 every register and output holds.
- Sum: sum = (obj_y + vcnt) mod 2^YW.
- Hit test: hit = &sum[YW-1:ROW_BITS].
- Row: row = sum[ROW_BITS-1:0].
- FSM IDLE:
  - y_stb=1: register hit and row; go to WAIT_ATTR.
  - attr_stb is ignored in IDLE.
- FSM WAIT_ATTR:
  - y_stb is ignored.
  - attr_stb=1 with hit=1 and count<MAX_SPR: latch flipx/flipy; count+=1; col=0; go to EMIT with r_valid=1 on the next cycle.
  - attr_stb=1 with hit=1 and count==MAX_SPR: set ovf=1 (sticky until line_start); go to IDLE with no output.
  - attr_stb=1 with hit=0: go to IDLE with no output.
- FSM EMIT:
  - r_addr = {col ^ {COL_BITS{flipx}}, row ^ {ROW_BITS{flipy}}}.
  - r_last = (col == COL_STEPS-1).
  - A transfer is r_valid & r_ready on a cen cycle.
  - On transfer with r_last=0: col+=1.
  - On transfer with r_last=1: r_valid=0, go to IDLE.
  - While r_ready=0, r_addr and r_last hold stable and r_valid stays 1.
  - y_stb and attr_stb are ignored in EMIT.
- Throughput: 1 word per cycle. Latency is 1 cycle from attr_stb to the first r_valid; 2 cycles minimum from y_stb.
- busy = (state != IDLE).
- line_start (cen=1) takes priority over everything in the same cycle:
  - state=IDLE, r_valid=0, count=0, ovf=0;
  - a coincident y_stb or attr_stb is dropped.
- A sprite already accepted into EMIT is aborted by line_start.
- Wrap-around: the sum wraps modulo 2^YW with no carry-out use. Example: obj_y=0x7F, vcnt=0x80 gives sum=0xFF, a hit on row 0xF.
- count saturates at MAX_SPR and never wraps.

Optional Feature:
- Macro: OBJ_STATS_EN.
- When defined:
  - adds output hit_cnt (8 bits), cleared by reset and by line_start;
  - hit_cnt increments on every hit, including dropped overflow hits, and saturates at 255;
  - obj_attr[2]=1 forces a miss (sprite disable).
- When undefined: no hit_cnt port, and obj_attr[2] is ignored.

Test Plan:
- Basic hit: defaults, vcnt=0x20, obj_y=0xD5 (sum 0xF5), attr=0x00, r_ready=1 -> r_addr 0x05, 0x15, 0x25, 0x35 on consecutive cycles; r_last only on 0x35; busy then drops.
- Flips: same stimulus with attr=0x03 -> r_addr 0x3A, 0x2A, 0x1A, 0x0A.
- Miss and wrap:
  - obj_y=0x10, vcnt=0x20 (sum 0x30) -> no r_valid; busy=0 after attr_stb.
  - obj_y=0x7F, vcnt=0x80 -> hit, row 0xF.
- Back-pressure: r_ready=0 for 3 cycles after the first valid -> r_addr stays 0x05 with r_valid=1; then all four words arrive in order with none lost or duplicated. Repeat with cen toggling every other cycle.
- Limit: MAX_SPR=2, three hitting sprites -> two emitted, third dropped, ovf=1. line_start clears ovf; the next hit is emitted.
- Abort and reset:
  - line_start during the 2nd EMIT word -> r_valid=0 next cycle, state IDLE.
  - line_start coincident with y_stb -> strobe ignored.
  - async reset mid-EMIT -> all outputs 0 immediately.
